cmd_ctrl_gen2: RTL and testbench

Second-generation system controller that decodes UART RX command frames into register-file writes and reads, ALU operations and TX-FIFO response pushes. Data, address and ALU-function widths are parametrised. Multi-byte results are serialised LSB-first, and a stalled multi-frame command is aborted by an inter-frame timeout. Sits between the RX master / TX FIFO and the register file / ALU / clock-gating cells.

---
 rtl/cmd_ctrl_pkg.sv | 44 ++++
 rtl/cmd_tx_serializer.sv | 52 +++++
 rtl/cmd_ctrl_gen2.sv | 199 +++++++++++++++++++
 tb/tb_cmd_ctrl_gen2.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_ctrl_pkg.sv
// Shared types, opcodes and default widths for the command controller.
// Purely declarative; no timing or backpressure of its own.
package cmd_ctrl_pkg;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_ADDR_W      = 4;
   localparam int DEF_FUN_W       = 4;
   localparam int DEF_RES_BYTES   = 2;
   localparam int DEF_TIMEOUT_CYC = 1023;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
   localparam logic [7:0] CMD_BRD     = 8'hEE;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
      ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX,
      BRD_ADDR, BRD_CNT, BRD_LOOP
   } state_t;

   // States waiting on the next RX frame of a command; these are the timed ones.
   function automatic logic frame_state(input state_t s);
      return s inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN, BRD_ADDR, BRD_CNT};
   endfunction

   // States where an RX frame is unexpected and is dropped with an error.
   function automatic logic wait_state(input state_t s);
      return s inside {RD_WAIT, ALU_WAIT, TX, BRD_LOOP};
   endfunction

   function automatic state_t cmd_next(input logic [7:0] cmd, input logic brd_en);
      case (cmd)
         CMD_WR:      return WR_ADDR;
         CMD_RD:      return RD_ADDR;
         CMD_ALU_OP:  return ALU_OPA;
         CMD_ALU_NOP: return ALU_FUN;
         CMD_BRD:     return brd_en ? BRD_ADDR : IDLE;
         default:     return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/cmd_tx_serializer.sv
// Holds a multi-frame result and pushes it LSB frame first into the TX FIFO.
// Latency: first push in the cycle after start; one frame per cycle while not stalled.
// Backpressure: ff_full holds the byte index and data, and suppresses the push.
module cmd_tx_serializer #(
   parameter int DATA_W    = 8,
   parameter int RES_BYTES = 2,
   parameter int IDX_W     = 2
) (
   input  logic                        i_clk,
   input  logic                        i_arst,
   input  logic                        start,
   input  logic [IDX_W-1:0]            nbytes,
   input  logic [RES_BYTES*DATA_W-1:0] din,
   input  logic                        ff_full,
   output logic [DATA_W-1:0]           tx_data,
   output logic                        tx_valid,
   output logic                        done
);

   logic [RES_BYTES*DATA_W-1:0] res;
   logic [IDX_W-1:0]            idx;
   logic [IDX_W-1:0]            last;
   logic                        active;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         res    <= '0;
         idx    <= '0;
         last   <= '0;
         active <= 1'b0;
      end else if (start) begin
         res    <= din;
         idx    <= '0;
         last   <= nbytes - 1'b1;
         active <= 1'b1;
      end else if (active && !ff_full) begin
         if (idx == last) active <= 1'b0;
         else             idx    <= idx + 1'b1;
      end
   end

   // The push is gated by the live full flag so a full FIFO never sees a write.
   assign tx_valid = active && !ff_full;
   assign done     = tx_valid && (idx == last);

   always_comb begin
      tx_data = '0;
      for (int k = 0; k < RES_BYTES; k++)
         if (int'(idx) == k) tx_data = res[k*DATA_W +: DATA_W];
   end

endmodule

// File: rtl/cmd_ctrl_gen2.sv
// Decodes UART RX command frames into RF writes/reads, ALU ops and TX pushes; burst read via CMD_CTRL_BURST_RD_EN.
// Latency: RF/ALU strobes one cycle after the last frame; TX push one cycle after read/ALU data valid.
// Backpressure: TX FIFO full stalls the serializer; RX frames arriving in wait states are dropped with o_err.
module cmd_ctrl_gen2
   import cmd_ctrl_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int FUN_W       = DEF_FUN_W,
   parameter int RES_BYTES   = DEF_RES_BYTES,
   parameter int OPA_ADDR    = 0,
   parameter int OPB_ADDR    = 1,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                        i_clk,
   input  logic                        i_arst,
   input  logic                        i_rx_d_valid,
   input  logic [DATA_W-1:0]           i_p_data,
   input  logic                        i_rd_valid,
   input  logic [DATA_W-1:0]           i_rd_data,
   input  logic                        i_out_valid,
   input  logic [RES_BYTES*DATA_W-1:0] i_alu_out,
   input  logic                        i_ff_full,
   output logic [ADDR_W-1:0]           o_address,
   output logic [DATA_W-1:0]           o_wr_data,
   output logic                        o_wr_en,
   output logic                        o_rd_en,
   output logic [FUN_W-1:0]            o_alu_fun,
   output logic                        o_alu_en,
   output logic                        o_clk_en,
   output logic [DATA_W-1:0]           o_tx_p_data,
   output logic                        o_tx_p_valid,
   output logic                        o_clk_div_en,
   output logic                        o_busy,
   output logic                        o_err
);

   localparam int RES_W = RES_BYTES * DATA_W;
   localparam int IDX_W = $clog2(RES_BYTES) + 1;
   localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
`ifdef CMD_CTRL_BURST_RD_EN
   localparam logic BRD_EN = 1'b1;
`else
   localparam logic BRD_EN = 1'b0;
`endif

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic [TO_W-1:0]   gap_cnt;
   logic              timeout;
   logic              ser_start;
   logic [IDX_W-1:0]  ser_nbytes;
   logic [RES_W-1:0]  ser_din;
   logic              ser_done;
`ifdef CMD_CTRL_BURST_RD_EN
   logic [ADDR_W-1:0] brd_addr;
   logic [DATA_W-1:0] brd_left;
   logic              brd_push;
`endif

   assign timeout = (TIMEOUT_CYC != 0) && frame_state(state) && !i_rx_d_valid &&
                    (gap_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      ser_start  = 1'b0;
      ser_nbytes = IDX_W'(1);
      ser_din    = RES_W'(i_rd_data);
      if (state == RD_WAIT && i_rd_valid) ser_start = 1'b1;
      if (state == ALU_WAIT && i_out_valid) begin
         ser_start  = 1'b1;
         ser_nbytes = IDX_W'(RES_BYTES);
         ser_din    = i_alu_out;
      end
`ifdef CMD_CTRL_BURST_RD_EN
      if (state == BRD_LOOP && !brd_push && i_rd_valid) ser_start = 1'b1;
`endif
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state     <= IDLE;
         wr_addr   <= '0;
         gap_cnt   <= '0;
         o_address <= '0;
         o_wr_data <= '0;
         o_wr_en   <= 1'b0;
         o_rd_en   <= 1'b0;
         o_alu_fun <= '0;
         o_alu_en  <= 1'b0;
         o_err     <= 1'b0;
`ifdef CMD_CTRL_BURST_RD_EN
         brd_addr  <= '0;
         brd_left  <= '0;
         brd_push  <= 1'b0;
`endif
      end else begin
         o_wr_en  <= 1'b0;
         o_rd_en  <= 1'b0;
         o_alu_en <= 1'b0;
         o_err    <= i_rx_d_valid && wait_state(state);

         if (i_rx_d_valid)            gap_cnt <= '0;
         else if (frame_state(state)) gap_cnt <= gap_cnt + 1'b1;

         if (timeout) begin
            o_err <= 1'b1;
            state <= IDLE;
         end else begin
            case (state)
               IDLE:     if (i_rx_d_valid) state <= cmd_next(i_p_data[7:0], BRD_EN);
               WR_ADDR:  if (i_rx_d_valid) begin
                  wr_addr <= i_p_data[ADDR_W-1:0];
                  state   <= WR_DATA;
               end
               WR_DATA:  if (i_rx_d_valid) begin
                  o_address <= wr_addr;
                  o_wr_data <= i_p_data;
                  o_wr_en   <= 1'b1;
                  state     <= IDLE;
               end
               RD_ADDR:  if (i_rx_d_valid) begin
                  o_address <= i_p_data[ADDR_W-1:0];
                  o_rd_en   <= 1'b1;
                  state     <= RD_WAIT;
               end
               RD_WAIT:  if (ser_start) state <= TX;
               ALU_OPA:  if (i_rx_d_valid) begin
                  o_address <= ADDR_W'(OPA_ADDR);
                  o_wr_data <= i_p_data;
                  o_wr_en   <= 1'b1;
                  state     <= ALU_OPB;
               end
               ALU_OPB:  if (i_rx_d_valid) begin
                  o_address <= ADDR_W'(OPB_ADDR);
                  o_wr_data <= i_p_data;
                  o_wr_en   <= 1'b1;
                  state     <= ALU_FUN;
               end
               ALU_FUN:  if (i_rx_d_valid) begin
                  o_alu_fun <= i_p_data[FUN_W-1:0];
                  o_alu_en  <= 1'b1;
                  state     <= ALU_WAIT;
               end
               ALU_WAIT: if (ser_start) state <= TX;
               TX:       if (ser_done) state <= IDLE;
`ifdef CMD_CTRL_BURST_RD_EN
               BRD_ADDR: if (i_rx_d_valid) begin
                  brd_addr <= i_p_data[ADDR_W-1:0];
                  state    <= BRD_CNT;
               end
               BRD_CNT:  if (i_rx_d_valid) begin
                  brd_left  <= (i_p_data == '0) ? DATA_W'(1) : i_p_data;
                  o_address <= brd_addr;
                  o_rd_en   <= 1'b1;
                  brd_push  <= 1'b0;
                  state     <= BRD_LOOP;
               end
               // Each read completes its push before the next address is issued.
               BRD_LOOP: if (ser_start) begin
                  brd_push <= 1'b1;
               end else if (brd_push && ser_done) begin
                  if (brd_left == DATA_W'(1)) begin
                     state <= IDLE;
                  end else begin
                     brd_left  <= brd_left - 1'b1;
                     brd_addr  <= brd_addr + 1'b1;
                     o_address <= brd_addr + 1'b1;
                     o_rd_en   <= 1'b1;
                     brd_push  <= 1'b0;
                  end
               end
`endif
               default:  state <= IDLE;
            endcase
         end
      end
   end

   assign o_busy       = (state != IDLE);
   assign o_clk_en     = state inside {ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT};
   assign o_clk_div_en = 1'b1;

   cmd_tx_serializer #(
      .DATA_W    (DATA_W),
      .RES_BYTES (RES_BYTES),
      .IDX_W     (IDX_W)
   ) u_ser (
      .i_clk    (i_clk),
      .i_arst   (i_arst),
      .start    (ser_start),
      .nbytes   (ser_nbytes),
      .din      (ser_din),
      .ff_full  (i_ff_full),
      .tx_data  (o_tx_p_data),
      .tx_valid (o_tx_p_valid),
      .done     (ser_done)
   );

endmodule

// File: tb/tb_cmd_ctrl_gen2.sv
// Directed bench for cmd_ctrl_gen2 with a short inter-frame timeout.
module tb_cmd_ctrl_gen2;

   logic        i_clk = 1'b0;
   logic        i_arst = 1'b1;
   logic        i_rx_d_valid = 1'b0;
   logic [7:0]  i_p_data = '0;
   logic        i_rd_valid = 1'b0;
   logic [7:0]  i_rd_data = '0;
   logic        i_out_valid = 1'b0;
   logic [15:0] i_alu_out = '0;
   logic        i_ff_full = 1'b0;
   logic [3:0]  o_address;
   logic [7:0]  o_wr_data;
   logic        o_wr_en;
   logic        o_rd_en;
   logic [3:0]  o_alu_fun;
   logic        o_alu_en;
   logic        o_clk_en;
   logic [7:0]  o_tx_p_data;
   logic        o_tx_p_valid;
   logic        o_clk_div_en;
   logic        o_busy;
   logic        o_err;

   cmd_ctrl_gen2 #(
      .DATA_W(8), .ADDR_W(4), .FUN_W(4), .RES_BYTES(2),
      .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT_CYC(16)
   ) dut (
      .i_clk(i_clk), .i_arst(i_arst),
      .i_rx_d_valid(i_rx_d_valid), .i_p_data(i_p_data),
      .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
      .i_out_valid(i_out_valid), .i_alu_out(i_alu_out),
      .i_ff_full(i_ff_full),
      .o_address(o_address), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
      .o_rd_en(o_rd_en), .o_alu_fun(o_alu_fun), .o_alu_en(o_alu_en),
      .o_clk_en(o_clk_en), .o_tx_p_data(o_tx_p_data), .o_tx_p_valid(o_tx_p_valid),
      .o_clk_div_en(o_clk_div_en), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   logic [7:0] push_q[$];
   logic [3:0] wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   logic [3:0] rd_q[$];
   logic [3:0] fun_q[$];

   // Event log sampled on the falling edge, away from the active edge.
   always @(negedge i_clk) begin
      if (!i_arst) begin
         if (o_tx_p_valid) push_q.push_back(o_tx_p_data);
         if (o_wr_en) begin
            wr_addr_q.push_back(o_address);
            wr_data_q.push_back(o_wr_data);
         end
         if (o_rd_en)  rd_q.push_back(o_address);
         if (o_alu_en) fun_q.push_back(o_alu_fun);
         if (o_err)    err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] f);
      i_rx_d_valid = 1'b1;
      i_p_data     = f;
      tick();
      i_rx_d_valid = 1'b0;
      i_p_data     = '0;
   endtask

   task automatic clear_log();
      push_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_q.delete();
      fun_q.delete();
   endtask

   task automatic wait_rd(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (o_rd_en) seen = 1'b1;
         else tick();
      end
   endtask

   task automatic serve_read();
      bit seen;
      wait_rd(seen);
      check("rd_en_seen", 32'(seen), 32'd1);
      i_rd_valid = 1'b1;
      i_rd_data  = 8'hA0 | {4'h0, o_address};
      tick();
      i_rd_valid = 1'b0;
      i_rd_data  = '0;
   endtask

   initial begin
      int e0;
      int n;
      bit found;
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int e0;
      int n;
      bit found;

      repeat (2) tick();
      check("rst_strobes", {o_wr_en, o_rd_en, o_alu_en, o_tx_p_valid, o_err}, 0);
      check("rst_busy_clken", {o_busy, o_clk_en}, 0);
      check("rst_clkdiv", o_clk_div_en, 1);
      check("rst_regs", {o_address, o_wr_data, o_alu_fun, o_tx_p_data}, 0);
      i_arst = 1'b0;
      tick();

      // Register write
      clear_log();
      send(8'hAA);
      check("wr_busy", o_busy, 1);
      send(8'h05);
      send(8'h3C);
      repeat (2) tick();
      check("wr_count", wr_data_q.size(), 1);
      check("wr_addr", wr_addr_q[0], 4'h5);
      check("wr_data", wr_data_q[0], 8'h3C);
      check("wr_idle", o_busy, 0);
      check("wr_hold", {o_address, o_wr_data}, 12'h53C);

      // Register read, data returns three cycles later
      clear_log();
      send(8'hBB);
      send(8'h05);
      tick();
      check("rd_count", rd_q.size(), 1);
      check("rd_addr", rd_q[0], 4'h5);
      repeat (2) tick();
      i_rd_valid = 1'b1;
      i_rd_data  = 8'h3C;
      tick();
      i_rd_valid = 1'b0;
      i_rd_data  = '0;
      repeat (4) tick();
      check("rd_push_count", push_q.size(), 1);
      check("rd_push_data", push_q[0], 8'h3C);
      check("rd_idle", o_busy, 0);

      // ALU with operands
      clear_log();
      send(8'hCC);
      send(8'h10);
      send(8'h20);
      send(8'h00);
      tick();
      check("alu_clk_en_wait", o_clk_en, 1);
      check("alu_wr_count", wr_data_q.size(), 2);
      check("alu_wr0", {wr_addr_q[0], wr_data_q[0]}, 12'h010);
      check("alu_wr1", {wr_addr_q[1], wr_data_q[1]}, 12'h120);
      check("alu_fun", {28'(fun_q.size()), fun_q[0]}, 32'h10);
      i_alu_out   = 16'h0030;
      i_out_valid = 1'b1;
      tick();
      i_out_valid = 1'b0;
      repeat (4) tick();
      check("alu_push_count", push_q.size(), 2);
      check("alu_push_bytes", {push_q[0], push_q[1]}, 16'h3000);
      check("alu_done", {o_busy, o_clk_en}, 0);

      // ALU on stored operands with a 4-cycle FIFO-full stall before the 2nd byte
      clear_log();
      send(8'hDD);
      send(8'h02);
      i_alu_out   = 16'h1234;
      i_out_valid = 1'b1;
      tick();
      i_out_valid = 1'b0;
      check("nop_first_push", {o_tx_p_valid, o_tx_p_data}, 9'h134);
      tick();
      i_ff_full = 1'b1;
      #1;
      check("nop_stall", {o_tx_p_valid, o_tx_p_data}, 9'h012);
      check("nop_stall_state", {o_busy, o_clk_en}, 2'b10);
      repeat (4) tick();
      i_ff_full = 1'b0;
      repeat (4) tick();
      check("nop_push_count", push_q.size(), 2);
      check("nop_push_bytes", {push_q[0], push_q[1]}, 16'h3412);
      check("nop_fun", fun_q[0], 4'h2);
      check("nop_idle", o_busy, 0);

      // Inter-frame timeout
      clear_log();
      e0 = err_cnt;
      send(8'hAA);
      send(8'h05);
      n = 0;
      found = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
         tick();
         if (o_err) begin
            n = i;
            found = 1'b1;
         end
      end
      check("to_cycles", n, 16);
      check("to_idle", o_busy, 0);
      tick();
      check("to_pulse_len", o_err, 0);
      check("to_err_count", err_cnt - e0, 1);
      check("to_no_write", wr_data_q.size(), 0);

      // Unknown command, then a stray frame while waiting for read data
      clear_log();
      e0 = err_cnt;
      send(8'h55);
      tick();
      check("unk_idle", {o_busy, o_err}, 0);
      send(8'hBB);
      send(8'h03);
      send(8'h77);
      tick();
      check("stray_err", err_cnt - e0, 1);
      check("stray_busy", o_busy, 1);
      i_rd_valid = 1'b1;
      i_rd_data  = 8'h5A;
      tick();
      i_rd_valid = 1'b0;
      repeat (4) tick();
      check("stray_push", {24'(push_q.size()), push_q[0]}, 32'h15A);

      // Reset in the middle of a write command
      clear_log();
      send(8'hAA);
      send(8'h05);
      i_arst = 1'b1;
      tick();
      check("mid_rst_outs", {o_busy, o_err, o_address, o_wr_data}, 0);
      i_arst = 1'b0;
      tick();
      send(8'h3C);
      repeat (3) tick();
      check("mid_rst_no_write", wr_data_q.size(), 0);

`ifdef CMD_CTRL_BURST_RD_EN
      // Burst read wrapping past the top of the address space
      clear_log();
      send(8'hEE);
      send(8'h0E);
      send(8'h03);
      for (int r = 0; r < 3; r++) serve_read();
      repeat (4) tick();
      check("brd_rd_count", rd_q.size(), 3);
      check("brd_rd_addrs", {rd_q[0], rd_q[1], rd_q[2]}, 12'hEF0);
      check("brd_push_count", push_q.size(), 3);
      check("brd_push_bytes", {push_q[0], push_q[1], push_q[2]}, 24'hAEAFA0);
      check("brd_idle", o_busy, 0);

      // Reset during the second read of a burst
      clear_log();
      send(8'hEE);
      send(8'h0E);
      send(8'h03);
      serve_read();
      wait_rd(found);
      check("brd_rst_2nd_rd", 32'(found), 32'd1);
      i_arst = 1'b1;
      tick();
      check("brd_rst_outs", {o_busy, o_rd_en, o_tx_p_valid, o_address}, 0);
      i_arst = 1'b0;
      i_rd_valid = 1'b1;
      i_rd_data  = 8'h55;
      tick();
      i_rd_valid = 1'b0;
      repeat (6) tick();
      check("brd_rst_push_count", push_q.size(), 1);
      check("brd_rst_push0", push_q[0], 8'hAE);
      check("brd_rst_idle", o_busy, 0);
`else
      // Without burst support 0xEE is just an unknown opcode
      clear_log();
      e0 = err_cnt;
      send(8'hEE);
      tick();
      check("ee_idle", o_busy, 0);
      send(8'h0E);
      send(8'h03);
      repeat (3) tick();
      check("ee_no_read", rd_q.size(), 0);
      check("ee_no_err", err_cnt - e0, 0);
      check("ee_still_idle", o_busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
